// File: rtl/pipe_muldiv_unit_if.sv
// Request/result bundle between the operation stage and the mul/div unit.
// master: operation stage side; slave: pipe_muldiv_unit side.
interface pipe_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic            cancel;
    logic            resultAccept;
    logic            busy;
    logic            resultValid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1Data, rs2Data,
        output cancel, resultAccept,
        input  busy, resultValid, result
    );

    modport slave (
        input  start, funct3, rs1Data, rs2Data,
        input  cancel, resultAccept,
        output busy, resultValid, result
    );
endinterface

// File: rtl/pipe_muldiv_unit.sv
// Iterative RV32M mul/div unit, radix 2^BITS_PER_CYCLE, shift-add / restoring.
// Define PIPE_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module pipe_muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    pipe_muldiv_unit_if.slave io
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = XLEN / BPC;
    localparam int CW  = $clog2(N);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} stateT;

    stateT state;
    stateT stateNext;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [2:0]        opReg;
    logic              negRes;
    logic [XLEN-1:0]   resultReg;

    logic            accept;
    logic            isDiv;
    logic            signedA;
    logic            signedB;
    logic            sgnA;
    logic            sgnB;
    logic            divZero;
    logic            ovf;
    logic            bypass;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;
    logic [XLEN-1:0] bypassRes;

    logic [XLEN+BPC-1:0] mulSum;
    logic [2*XLEN-1:0]   mulNext;
    logic [XLEN:0]       remT;
    logic [XLEN-1:0]     quoT;
    logic [2*XLEN-1:0]   divNext;
    logic [2*XLEN-1:0]   prodFix;
    logic [XLEN-1:0]     quoFix;
    logic [XLEN-1:0]     remFix;
    logic [XLEN-1:0]     fixRes;

    assign accept = io.start && !io.cancel &&
                    (state == IDLE ||
                     (state == DONE && io.resultAccept));

    assign isDiv   = io.funct3[2];
    assign signedA = io.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    assign signedB = io.funct3 inside {3'b001, 3'b100, 3'b110};
    assign sgnA    = signedA & io.rs1Data[XLEN-1];
    assign sgnB    = signedB & io.rs2Data[XLEN-1];
    assign magA    = sgnA ? -io.rs1Data : io.rs1Data;
    assign magB    = sgnB ? -io.rs2Data : io.rs2Data;

    assign divZero = isDiv && (io.rs2Data == '0);
    assign ovf     = (io.funct3 inside {3'b100, 3'b110}) &&
                     (io.rs1Data == MIN_VAL) && (&io.rs2Data);

`ifdef PIPE_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fastA;
    logic [2*XLEN-1:0] fastB;
    logic [2*XLEN-1:0] fastProd;

    // Sign-extended to 2*XLEN so one unsigned product covers every variant
    assign fastA    = {{XLEN{sgnA}}, io.rs1Data};
    assign fastB    = {{XLEN{sgnB}}, io.rs2Data};
    assign fastProd = fastA * fastB;
    assign bypass   = divZero | ovf | !isDiv;
`else
    assign bypass   = divZero | ovf;
`endif

    always_comb begin
        bypassRes = '0;
        if (divZero) begin
            bypassRes = io.funct3[1] ? io.rs1Data : '1;
        end else if (ovf) begin
            bypassRes = io.funct3[1] ? '0 : MIN_VAL;
        end
`ifdef PIPE_MULDIV_FAST_MUL_EN
        else if (!isDiv) begin
            bypassRes = (io.funct3[1:0] == 2'b00) ?
                        fastProd[XLEN-1:0] :
                        fastProd[2*XLEN-1:XLEN];
        end
`endif
    end

    // Multiply: hi half accumulates, lo half shifts multiplier digits out
    always_comb begin
        mulSum = {{BPC{1'b0}}, acc[2*XLEN-1:XLEN]};
        for (int j = 0; j < BPC; j++) begin
            if (acc[j])
                mulSum = mulSum + ({{BPC{1'b0}}, mcand} << j);
        end
        mulNext = {mulSum, acc[XLEN-1:BPC]};
    end

    // Divide: hi half is the partial remainder, lo half the quotient
    always_comb begin
        remT = {1'b0, acc[2*XLEN-1:XLEN]};
        quoT = acc[XLEN-1:0];
        for (int j = 0; j < BPC; j++) begin
            remT = {remT[XLEN-1:0], quoT[XLEN-1]};
            quoT = {quoT[XLEN-2:0], 1'b0};
            if (remT >= {1'b0, mcand}) begin
                remT    = remT - {1'b0, mcand};
                quoT[0] = 1'b1;
            end
        end
        divNext = {remT[XLEN-1:0], quoT};
    end

    always_comb begin
        prodFix = negRes ? -acc : acc;
        quoFix  = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remFix  = negRes ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fixRes  = '0;
        unique case (1'b1)
            opReg == 3'b000:
                fixRes = prodFix[XLEN-1:0];
            !opReg[2] && (opReg[1:0] != 2'b00):
                fixRes = prodFix[2*XLEN-1:XLEN];
            opReg[2] && !opReg[1]:
                fixRes = quoFix;
            default:
                fixRes = remFix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        io.busy        = 1'b0;
        io.resultValid = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) stateNext = bypass ? DONE : ITER;
            end
            ITER: begin
                io.busy = 1'b1;
                if (cnt == CW'(N - 1)) stateNext = FIX;
            end
            FIX: begin
                io.busy   = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                io.resultValid = 1'b1;
                if (accept)               stateNext = bypass ? DONE : ITER;
                else if (io.resultAccept) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (io.cancel) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            opReg     <= '0;
            negRes    <= 1'b0;
            resultReg <= '0;
        end else if (accept) begin
            cnt    <= '0;
            opReg  <= io.funct3;
            negRes <= (isDiv && io.funct3[1]) ? sgnA : (sgnA ^ sgnB);
            mcand  <= isDiv ? magB : magA;
            acc    <= {{XLEN{1'b0}}, isDiv ? magA : magB};
            if (bypass) resultReg <= bypassRes;
        end else if (state == ITER) begin
            acc <= opReg[2] ? divNext : mulNext;
            if (cnt != CW'(N - 1)) cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
            resultReg <= fixRes;
        end
    end

    assign io.result = resultReg;
endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Randomized + directed bench for pipe_muldiv_unit against an arithmetic model.
// BPC selects the radix under test; honours PIPE_MULDIV_FAST_MUL_EN.
module tb_pipe_muldiv_unit;
    localparam int XLEN  = 32;
    parameter  int BPC   = 1;
    localparam int N     = XLEN / BPC;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_muldiv_unit_if #(.XLEN(XLEN)) io ();

    pipe_muldiv_unit #(
        .XLEN          (XLEN),
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0)                                r = '1;
                else if (a == 32'h80000000 && b == '1)     r = a;
                else                                       r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0)                                r = a;
                else if (a == 32'h80000000 && b == '1)     r = '0;
                else                                       r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int expLat(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == '1)
            return 1;
`ifdef PIPE_MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return N + 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request (optionally with resultAccept) for one edge
    task automatic launch(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic withAck);
        io.start        = 1'b1;
        io.resultAccept = withAck;
        io.funct3       = op;
        io.rs1Data      = a;
        io.rs2Data      = b;
        step();
        io.start        = 1'b0;
        io.resultAccept = 1'b0;
        io.funct3       = 3'($urandom);
        io.rs1Data      = $urandom;
        io.rs2Data      = $urandom;
        check("busy-after-accept", 32'(io.busy), 32'(expLat(op, a, b) > 1));
        check("rv-after-accept", 32'(io.resultValid),
              32'(expLat(op, a, b) == 1));
    endtask

    task automatic collect(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int cyc = 1;
        while (!io.resultValid && cyc < LIMIT) begin
            step();
            cyc++;
        end
        check({tag, "-lat"}, 32'(cyc), 32'(expLat(op, a, b)));
        check({tag, "-res"}, io.result, exp);
        check({tag, "-busy"}, 32'(io.busy), 32'd0);
    endtask

    task automatic ack();
        io.resultAccept = 1'b1;
        step();
        io.resultAccept = 1'b0;
        check("rv-after-ack", 32'(io.resultValid), 32'd0);
    endtask

    logic [2:0]  dOp [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                              3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] dA  [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'd5, 32'd5,
                              32'h80000000, 32'h80000000};
    logic [31:0] dB  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] dExp[12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE,
                              32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                              32'h80000000, 32'd0};

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        io.start        = 1'b0;
        io.funct3       = '0;
        io.rs1Data      = '0;
        io.rs2Data      = '0;
        io.cancel       = 1'b0;
        io.resultAccept = 1'b0;

        #12;
        check("rst-busy", 32'(io.busy), 32'd0);
        check("rst-rv", 32'(io.resultValid), 32'd0);
        check("rst-result", io.result, 32'd0);
        #10 rst = 1'b1;
        step();
        check("idle-rv", 32'(io.resultValid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            launch(dOp[i], dA[i], dB[i], 1'b0);
            collect($sformatf("dir%0d", i), dOp[i], dA[i], dB[i], dExp[i]);
            ack();
        end

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       a = 32'h80000000;
                3:       b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            launch(op, a, b, 1'b0);
            collect($sformatf("rnd%0d", i), op, a, b, refModel(op, a, b));
            ack();
        end

        // Cancel in ITER together with a start: both must be dropped
        launch(3'd5, $urandom, $urandom | 32'd1, 1'b0);
        repeat (9) step();
        io.cancel  = 1'b1;
        io.start   = 1'b1;
        io.funct3  = 3'd0;
        io.rs1Data = 32'd3;
        io.rs2Data = 32'd4;
        step();
        io.cancel  = 1'b0;
        io.start   = 1'b0;
        check("cancel-busy", 32'(io.busy), 32'd0);
        check("cancel-rv", 32'(io.resultValid), 32'd0);
        seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            if (io.resultValid) seen++;
        end
        check("cancel-norv", 32'(seen), 32'd0);
        launch(3'd5, 32'd9, 32'd3, 1'b0);
        collect("post-cancel", 3'd5, 32'd9, 32'd3, 32'd3);
        ack();

        launch(3'd5, 32'd100, 32'd7, 1'b0);
        collect("b2b-first", 3'd5, 32'd100, 32'd7, 32'd14);
        launch(3'd0, 32'd3, 32'd4, 1'b1);
        collect("b2b-second", 3'd0, 32'd3, 32'd4, 32'd12);
        ack();

        // Asynchronous reset in the middle of an iteration
        launch(3'd4, $urandom, 32'd7, 1'b0);
        repeat (5) step();
        #2 rst = 1'b0;
        #1;
        check("midrst-busy", 32'(io.busy), 32'd0);
        check("midrst-rv", 32'(io.resultValid), 32'd0);
        check("midrst-result", io.result, 32'd0);
        step();
        check("midrst-hold", 32'(io.busy | io.resultValid), 32'd0);
        #3 rst = 1'b1;
        step();
        launch(3'd7, 32'd100, 32'd7, 1'b0);
        collect("post-rst", 3'd7, 32'd100, 32'd7, 32'd2);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_muldiv_unit.md
# pipe_muldiv_unit

Iterative, parametrised RV32M multiply/divide execution unit that sits beside the operation stage of the core pipe. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request, processes it over several cycles, and holds the result until the pipe consumes it. The operation stage holds its pipe stall while `busy` is high. The unit is a multi-cycle successor to the single-cycle ALU, generalised in operand width and radix (bits retired per cycle).

## Interface
- `XLEN`, 32: operand and result width. Must be even and ≥ 8.
- `BITS_PER_CYCLE`, 1: quotient/multiplier bits processed per iteration. Legal values are 1, 2 and 4, and the value must divide `XLEN`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: request strobe. Sampled only when the unit can accept a request.
- `funct3` input 3: RV32M operation code (000 MUL … 111 REMU).
- `rs1Data` input `XLEN`: dividend / multiplicand.
- `rs2Data` input `XLEN`: divisor / multiplier.
- `cancel` input 1: abort the current operation (trap or flush).
- `resultAccept` input 1: pipe consumes the held result.
- `busy` output 1: high while an operation is being computed.
- `resultValid` output 1: high while `result` is held and valid.
- `result` output `XLEN`: operation result.

## Operation
- **States:** IDLE, ITER, FIX, DONE. `N = XLEN/BITS_PER_CYCLE` iterations.
- **Accept condition:** `start` is accepted when the state is IDLE, or DONE with `resultAccept` high in the same cycle.
  - On accept, operands and `funct3` are latched. Later input changes have no effect.
  - `start` outside the accept condition is ignored.
- **Sign handling:** operands are converted to magnitudes according to signedness.
  - MULH: both signed. MULHSU: rs1 signed. DIV/REM: both signed. All others unsigned.
  - FIX applies the sign correction: product sign = XOR of operand signs; quotient sign = XOR of operand signs; remainder sign = dividend sign.
- **ITER, multiply:** radix-2^`BITS_PER_CYCLE` shift-add into a `2*XLEN` accumulator. MUL returns the low `XLEN` bits; the MULH variants return the high `XLEN` bits.
- **ITER, divide:** restoring division, `BITS_PER_CYCLE` quotient bits per cycle.
- **Special cases** bypass ITER/FIX and go directly from accept to DONE:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (most-negative ÷ −1): DIV returns the most-negative value; REM returns 0.
- **Transitions:**
  - IDLE→ITER on accept.
  - ITER→FIX when the iteration counter reaches N−1.
  - FIX→DONE.
  - DONE→IDLE on `resultAccept` without `start`; DONE→ITER (or DONE) on `resultAccept` with `start`.
- **Cancel:** `cancel` forces IDLE at the next edge from any state and discards the result. It has priority over `start` and `resultAccept`.
- **Outputs:**
  - `busy` = state ∈ {ITER, FIX}.
  - `resultValid` = state == DONE.
  - `result` is registered and holds its value from entry into DONE until the next accept.

## Timing
- **Reset** (asynchronous assertion, synchronous deassertion external to the block): state IDLE, counter 0, `busy`=0, `resultValid`=0, `result`=0.
- **Normal latency:** accept at edge 0 gives `busy`=1 after edge 0 and `resultValid`=1 after edge N+1. That is N+2 cycles, e.g. 34 cycles for 32/1 and 10 cycles for 32/4.
- **Special-case latency:** `resultValid`=1 after edge 0 (1 cycle); `busy` never rises.
- **Back-to-back:** `resultAccept` and `start` in the same DONE cycle give zero idle cycles between operations.
- **Reset mid-operation:** the unit returns to its reset state immediately. No partial result is ever presented.
- **Counter:** ceil(log2(N)) bits, cleared on accept. There is no wrap-around, because ITER exits at N−1.

## Configuration
- `PIPE_MULDIV_FAST_MUL_EN`.
  - **Defined:** MUL/MULH/MULHSU/MULHU use a combinational `XLEN`×`XLEN` multiplier and go from accept directly to DONE (1-cycle latency, `busy` never rises). Division is unchanged.
  - **Undefined:** all multiplies are iterative with N+2 latency, and no hardware multiplier is inferred.

## Test plan
- XLEN=32, BPC=1: MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB, `resultValid` exactly 34 cycles after accept. With the macro defined: 1 cycle.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU → 2. Repeat all with BPC=2 and BPC=4 (latencies 18 and 10).
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each valid 1 cycle after accept with `busy`=0. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Assert `cancel` in ITER cycle 10 together with `start` → IDLE next edge, `resultValid` never rises. A new DIVU 9/3 then completes with 3.
- In DONE, assert `resultAccept`+`start` (MUL 3×4) → back-to-back acceptance, `result`=12 after 34 cycles. Assert `rst` low mid-ITER → all outputs 0 immediately.
